// File: rtl/onewire_bit_master.sv
// 1-wire bit-level master timing engine.
// Runs one standard-speed slot per accepted command (reset/presence, write 0,
// write 1, read). All slot timing is counted from the accept edge with a
// microsecond prescaler. The line is sampled through a 2-flop synchroniser,
// and one result bit is returned per slot.
module onewire_bit_master #(
    parameter int CLK_FRQ = 24000000,
    parameter int CDIV    = CLK_FRQ / 1000000,
    parameter int CW      = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    output logic       rsp_valid,
    output logic       rsp_data,
    output logic       busy,
    output logic       owr_oe,
    input  logic       owr_i
);

    localparam int            PW        = (CDIV > 1) ? $clog2(CDIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(CDIV - 1);
    localparam logic [1:0]    CMD_RESET = 2'b00;
    localparam logic [1:0]    CMD_WR0   = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_WAIT,
        S_RECOVER
    } state_t;

    state_t        state_reg, state_next;
    logic [1:0]    cmd_reg;
    logic [PW-1:0] pre_reg;
    logic [CW-1:0] us_reg;
    logic [1:0]    sync_reg;
    logic          owr_s;
    logic          sample_reg;
    logic          sampled_reg;
    logic          rsp_data_reg;
    logic          owr_oe_reg, owr_oe_next;
    logic [CW-1:0] low_us, smp_us, slot_us;
    logic          accept, pre_wrap, low_end, smp_now, slot_end, resp_bit;

    // Slot timing for the latched command: drive-low, sample point, slot length (us)
    always_comb begin
        case (cmd_reg)
            CMD_RESET: begin
                low_us  = CW'(480);
                smp_us  = CW'(550);
                slot_us = CW'(960);
            end
            CMD_WR0: begin
                low_us  = CW'(60);
                smp_us  = CW'(15);
                slot_us = CW'(70);
            end
            default: begin
                low_us  = CW'(6);
                smp_us  = CW'(15);
                slot_us = CW'(70);
            end
        endcase
    end

    // Counter values seen at edge n equal n-1 cycles since accept, so the
    // "edge 1+T(x)" events match a counter value of exactly x us, prescaler 0.
    assign owr_s     = sync_reg[1];
    assign pre_wrap  = (pre_reg == PRE_LAST);
    assign low_end   = (us_reg == low_us) && (pre_reg == '0);
    assign smp_now   = (us_reg == smp_us) && (pre_reg == '0);
    assign slot_end  = (state_reg == S_RECOVER) && (us_reg == slot_us - CW'(1)) && pre_wrap;

    // Ready is also raised in the final slot cycle, so a waiting command is
    // taken on the response cycle with no idle gap between slots.
    assign cmd_ready = (state_reg == S_IDLE) || slot_end;
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid && cmd_ready;
    assign resp_bit  = (cmd_reg == CMD_RESET) ? ~sample_reg : sample_reg;
    assign rsp_valid = slot_end;
    assign rsp_data  = slot_end ? resp_bit : rsp_data_reg;
    assign owr_oe    = owr_oe_reg;

    // Next-state and line-drive decode
    always_comb begin
        state_next  = state_reg;
        owr_oe_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept) state_next = S_LOW;
            end
            S_LOW: begin
                if (low_end) state_next = S_WAIT;
                else         owr_oe_next = 1'b1;
            end
            S_WAIT: begin
                if (sampled_reg || smp_now) state_next = S_RECOVER;
            end
            S_RECOVER: begin
                if (slot_end) state_next = accept ? S_LOW : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State and registered line drive; reset releases the line immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= S_IDLE;
            owr_oe_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            owr_oe_reg <= owr_oe_next;
        end
    end

    // Two-flop synchroniser for the asynchronous line input (idles high)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_reg <= 2'b11;
        else          sync_reg <= {sync_reg[0], owr_i};
    end

    // Microsecond timebase, restarted on every accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_reg <= '0;
            us_reg  <= '0;
        end else if (accept) begin
            pre_reg <= '0;
            us_reg  <= '0;
        end else if (state_reg != S_IDLE) begin
            if (pre_wrap) begin
                pre_reg <= '0;
                us_reg  <= us_reg + CW'(1);
            end else begin
                pre_reg <= pre_reg + PW'(1);
            end
        end
    end

    // Command latch and single line sample per slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_reg     <= 2'b00;
            sample_reg  <= 1'b0;
            sampled_reg <= 1'b0;
        end else if (accept) begin
            cmd_reg     <= cmd;
            sampled_reg <= 1'b0;
        end else if ((state_reg == S_LOW || state_reg == S_WAIT) && smp_now && !sampled_reg) begin
            sample_reg  <= owr_s;
            sampled_reg <= 1'b1;
        end
    end

    // Response bit holds between responses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      rsp_data_reg <= 1'b0;
        else if (slot_end) rsp_data_reg <= resp_bit;
    end

endmodule

// File: tb/tb_onewire_bit_master.sv
// Self-checking bench for onewire_bit_master at 24 MHz (CDIV=24).
// Expected slot behaviour comes from the slot timing table and the line
// level at the sample instant (master drive OR slave pull-down window).
module tb_onewire_bit_master;

    localparam int CDIV = 24;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd       = 2'b00;
    logic       slave_low = 1'b0;
    logic       cmd_ready, rsp_valid, rsp_data, busy, owr_oe;
    logic       owr_i;

    int tests_run    = 0;
    int tests_failed = 0;

    // Open-drain line: low when the master or the slave pulls it
    assign owr_i = ~(owr_oe | slave_low);

    always #5 clk = ~clk;

    onewire_bit_master #(.CLK_FRQ(24000000)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .owr_oe    (owr_oe),
        .owr_i     (owr_i)
    );

    function automatic int low_us(input logic [1:0] c);
        case (c)
            2'b00:   return 480;
            2'b01:   return 60;
            default: return 6;
        endcase
    endfunction

    function automatic int smp_us(input logic [1:0] c);
        return (c == 2'b00) ? 550 : 15;
    endfunction

    function automatic int slot_us(input logic [1:0] c);
        return (c == 2'b00) ? 960 : 70;
    endfunction

    // Result bit from the line level at the sample instant
    function automatic logic exp_bit(input logic [1:0] c, input int lo, input int hi);
        int s;
        logic line_low;
        s        = smp_us(c);
        line_low = (s < low_us(c)) || (lo <= s && s < hi);
        return (c == 2'b00) ? line_low : !line_low;
    endfunction

    // Issue one command and observe its slot (k = edges since accept).
    // Slave pulls the line low for k in [lo*CDIV, hi*CDIV).
    task automatic measure_slot(input logic [1:0] c, input int lo, input int hi,
                                output int oe_cnt, output int oe_first, output int oe_last,
                                output int rsp_k, output int rsp_cnt, output logic rsp_bit,
                                output logic rdy_at_rsp, output logic data_after);
        int guard;
        int slot_cyc;
        guard    = 0;
        slot_cyc = slot_us(c) * CDIV;
        @(negedge clk);
        while (!cmd_ready && guard < 30000) begin
            @(negedge clk);
            guard++;
        end
        cmd       = c;
        cmd_valid = 1'b1;
        @(posedge clk);
        oe_cnt = 0; oe_first = -1; oe_last = -1;
        rsp_k = -1; rsp_cnt = 0; rsp_bit = 1'bx; rdy_at_rsp = 1'b0;
        for (int k = 0; k <= slot_cyc + 4; k++) begin
            @(negedge clk);
            if (k == 0) cmd_valid = 1'b0;
            slave_low = (k >= lo * CDIV) && (k < hi * CDIV);
            if (owr_oe === 1'b1) begin
                oe_cnt++;
                if (oe_first < 0) oe_first = k;
                oe_last = k;
            end
            if (rsp_valid === 1'b1) begin
                rsp_cnt++;
                if (rsp_k < 0) begin
                    rsp_k      = k + 1;
                    rsp_bit    = rsp_data;
                    rdy_at_rsp = cmd_ready;
                end
            end
        end
        slave_low  = 1'b0;
        data_after = rsp_data;
        $display("[TB] slot cmd=%b slave=%0d..%0d oe_cnt=%0d rsp_edge=%0d rsp_data=%b",
                 c, lo, hi, oe_cnt, rsp_k, rsp_bit);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        cmd_valid = 1'b1;
        cmd = 2'b01;
        repeat (4) @(negedge clk);
        tests_run++;
        if (owr_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_oe got %b want 0", owr_oe); end
        tests_run++;
        if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++;
        if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        tests_run++;
        if (rsp_data !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_data got %b want 0", rsp_data); end
        cmd_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        $display("[TB] reset checked");
    endtask

    task automatic test_directed;
        logic [1:0] t_cmd [6] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00};
        int         t_lo  [6] = '{0, 0, 0, 0, 500, 0};
        int         t_hi  [6] = '{0, 0, 30, 10, 620, 0};
        int oe_cnt, oe_first, oe_last, rsp_k, rsp_cnt;
        logic rsp_bit, rdy, data_after, eb;
        int tl, ts;
        for (int i = 0; i < 6; i++) begin
            measure_slot(t_cmd[i], t_lo[i], t_hi[i], oe_cnt, oe_first, oe_last,
                         rsp_k, rsp_cnt, rsp_bit, rdy, data_after);
            tl = low_us(t_cmd[i]) * CDIV;
            ts = slot_us(t_cmd[i]) * CDIV;
            eb = exp_bit(t_cmd[i], t_lo[i], t_hi[i]);
            tests_run++;
            if (oe_first !== 1) begin tests_failed++; $display("FAIL dir%0d_oe_rise got %0d want 1", i, oe_first); end
            tests_run++;
            if (oe_cnt !== tl || oe_last !== tl) begin
                tests_failed++;
                $display("FAIL dir%0d_oe_len got cnt=%0d last=%0d want %0d", i, oe_cnt, oe_last, tl);
            end
            tests_run++;
            if (rsp_cnt !== 1 || rsp_k !== ts) begin
                tests_failed++;
                $display("FAIL dir%0d_rsp_edge got edge=%0d pulses=%0d want edge=%0d pulses=1", i, rsp_k, rsp_cnt, ts);
            end
            tests_run++;
            if (rsp_bit !== eb) begin tests_failed++; $display("FAIL dir%0d_rsp_data got %b want %b", i, rsp_bit, eb); end
            tests_run++;
            if (rdy !== 1'b1) begin tests_failed++; $display("FAIL dir%0d_ready_at_rsp got %b want 1", i, rdy); end
            tests_run++;
            if (data_after !== eb) begin tests_failed++; $display("FAIL dir%0d_rsp_hold got %b want %b", i, data_after, eb); end
        end
    endtask

    task automatic test_random;
        int oe_cnt, oe_first, oe_last, rsp_k, rsp_cnt;
        logic rsp_bit, rdy, data_after, eb;
        logic [1:0] c;
        int lo, hi;
        for (int i = 0; i < 6; i++) begin
            c = 2'($urandom_range(1, 3));
            do begin
                lo = int'($urandom_range(0, 60));
                hi = lo + int'($urandom_range(1, 40));
                if (hi > 69) hi = 69;
            end while ((lo >= 14 && lo <= 16) || (hi >= 14 && hi <= 16));
            measure_slot(c, lo, hi, oe_cnt, oe_first, oe_last, rsp_k, rsp_cnt, rsp_bit, rdy, data_after);
            eb = exp_bit(c, lo, hi);
            tests_run++;
            if (oe_cnt !== low_us(c) * CDIV) begin
                tests_failed++;
                $display("FAIL rnd%0d_oe_len got %0d want %0d", i, oe_cnt, low_us(c) * CDIV);
            end
            tests_run++;
            if (rsp_k !== slot_us(c) * CDIV) begin
                tests_failed++;
                $display("FAIL rnd%0d_rsp_edge got %0d want %0d", i, rsp_k, slot_us(c) * CDIV);
            end
            tests_run++;
            if (rsp_bit !== eb) begin tests_failed++; $display("FAIL rnd%0d_rsp_data got %b want %b", i, rsp_bit, eb); end
        end
    endtask

    task automatic test_back_to_back;
        int rises[$];
        int rsps[$];
        int widths[$];
        int w, bad_bits, guard;
        logic prev;
        w = 0; bad_bits = 0; guard = 0; prev = 1'b0;
        @(negedge clk);
        while (!cmd_ready && guard < 30000) begin @(negedge clk); guard++; end
        cmd = 2'b11;
        cmd_valid = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 3 * 1680 + 20; n++) begin
            @(negedge clk);
            if (n % 1680 == 50)   cmd = 2'b01;
            if (n % 1680 == 1600) cmd = 2'b11;
            if (owr_oe === 1'b1 && !prev) rises.push_back(n);
            if (owr_oe === 1'b1) w++;
            if (owr_oe !== 1'b1 && prev) begin widths.push_back(w); w = 0; end
            prev = (owr_oe === 1'b1);
            if (rsp_valid === 1'b1) begin
                rsps.push_back(n);
                if (rsp_data !== 1'b1) bad_bits++;
            end
        end
        cmd_valid = 1'b0;
        tests_run++;
        if (rises.size() < 3 || rises[1] - rises[0] != 1680 || rises[2] - rises[1] != 1680) begin
            tests_failed++;
            $display("FAIL b2b_period got %0d rises, gaps %0d %0d want 1680",
                     rises.size(), (rises.size() > 1) ? rises[1] - rises[0] : -1,
                     (rises.size() > 2) ? rises[2] - rises[1] : -1);
        end
        tests_run++;
        if (widths.size() < 3 || widths[0] != 144 || widths[1] != 144 || widths[2] != 144) begin
            tests_failed++;
            $display("FAIL b2b_oe_width got %0d pulses first=%0d want 144 each",
                     widths.size(), (widths.size() > 0) ? widths[0] : -1);
        end
        tests_run++;
        if (rsps.size() != 3 || rsps[1] - rsps[0] != 1680 || rsps[2] - rsps[1] != 1680) begin
            tests_failed++;
            $display("FAIL b2b_rsp got %0d responses want 3 spaced 1680", rsps.size());
        end
        tests_run++;
        if (bad_bits != 0) begin tests_failed++; $display("FAIL b2b_rsp_data got %0d wrong bits want 0", bad_bits); end
        guard = 0;
        while (!cmd_ready && guard < 3000) begin @(negedge clk); guard++; end
        tests_run++;
        if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_drain got ready=%b want 1", cmd_ready); end
        $display("[TB] back-to-back rises=%0d responses=%0d", rises.size(), rsps.size());
    endtask

    task automatic test_async_reset;
        int guard, rsp_seen, oe_seen;
        int oe_cnt, oe_first, oe_last, rsp_k, rsp_cnt;
        logic rsp_bit, rdy, data_after;
        guard = 0; rsp_seen = 0; oe_seen = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 30000) begin @(negedge clk); guard++; end
        cmd = 2'b01;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (699) @(negedge clk);
        @(posedge clk);
        #1;
        tests_run++;
        if (owr_oe !== 1'b1) begin tests_failed++; $display("FAIL arst_pre_oe got %b want 1", owr_oe); end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (owr_oe !== 1'b0) begin tests_failed++; $display("FAIL arst_oe got %b want 0", owr_oe); end
        tests_run++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL arst_ready got ready=%b busy=%b want 1/0", cmd_ready, busy);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int n = 0; n < 1700; n++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) rsp_seen++;
            if (owr_oe === 1'b1) oe_seen++;
        end
        tests_run++;
        if (rsp_seen != 0 || oe_seen != 0) begin
            tests_failed++;
            $display("FAIL arst_dropped got rsp=%0d oe=%0d want 0/0", rsp_seen, oe_seen);
        end
        measure_slot(2'b11, 0, 0, oe_cnt, oe_first, oe_last, rsp_k, rsp_cnt, rsp_bit, rdy, data_after);
        tests_run++;
        if (oe_cnt !== 144 || rsp_k !== 1680 || rsp_bit !== 1'b1) begin
            tests_failed++;
            $display("FAIL arst_read_after got oe=%0d edge=%0d data=%b want 144/1680/1", oe_cnt, rsp_k, rsp_bit);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
